// File: rtl/line_output_scheduler_if.sv
// rtl/line_output_scheduler_if.sv - line buffer bank and video output signal bundle for the line scheduler
interface line_output_scheduler_if;
  logic        hsync_in;
  logic        vsync_in;
  logic [9:0]  line_width;
  logic        bank_empty;
  logic [23:0] bank_q;
  logic        swap_bank;
  logic        read_ack;
  logic        de;
  logic [23:0] rgb_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        underrun;

  modport master (
    output hsync_in, vsync_in, line_width, bank_empty, bank_q,
    input  swap_bank, read_ack, de, rgb_out, hsync_out, vsync_out, underrun
  );

  modport slave (
    input  hsync_in, vsync_in, line_width, bank_empty, bank_q,
    output swap_bank, read_ack, de, rgb_out, hsync_out, vsync_out, underrun
  );
endinterface

// File: rtl/line_output_scheduler.sv
// rtl/line_output_scheduler.sv - centred fixed-width line readout from the double-banked line buffer
// Optional sticky underrun flag enabled by LINE_SCHED_UNDERRUN_EN.
module line_output_scheduler #(
  parameter int OUT_WIDTH = 512,
  parameter int HS_LEAD   = 15,
  parameter int HS_OFFSET = 6
) (
  input  logic                    clk_vid,
  input  logic                    reset,
  line_output_scheduler_if.slave  bus
);
  localparam logic [9:0] OUT_W   = 10'(OUT_WIDTH);
  localparam logic [9:0] LEAD    = 10'(HS_LEAD);
  localparam logic [9:0] HS_MARK = 10'(HS_LEAD - HS_OFFSET);

  typedef enum logic [2:0] {IDLE, HS_WAIT, PAD_L, ACTIVE, PAD_R, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [9:0]  l_q, l_d, w_q, w_d, r_q, r_d, x_q, x_d;
  logic        prev_hsync_q, prev_hsync_d;
  logic        prev_vsync_q, prev_vsync_d;
  logic        swap_bank_q, swap_bank_d;
  logic        read_ack_q, read_ack_d;
  logic        de_q, de_d;
  logic [23:0] rgb_out_q, rgb_out_d;
  logic        hsync_out_q, hsync_out_d;
  logic        vsync_out_q, vsync_out_d;
  logic        underrun_q, underrun_d;

  logic        hs_edge, vs_edge;
  logic [9:0]  w_new, pad_new;

  always_comb begin
    hs_edge      = bus.hsync_in & ~prev_hsync_q;
    vs_edge      = bus.vsync_in & ~prev_vsync_q;
    w_new        = (bus.line_width < OUT_W) ? bus.line_width : OUT_W;
    pad_new      = OUT_W - w_new;

    state_d      = state_q;
    cnt_d        = cnt_q - 10'd1;
    l_d          = l_q;
    w_d          = w_q;
    r_d          = r_q;
    x_d          = x_q;
    prev_hsync_d = bus.hsync_in;
    prev_vsync_d = bus.vsync_in;

    // cnt_q holds the cycles left in the current state, including this one
    unique case (state_q)
      IDLE: cnt_d = cnt_q;
      HS_WAIT: if (cnt_q == 10'd1) begin
        if (l_q != 10'd0)      begin state_d = PAD_L;  cnt_d = l_q; end
        else if (w_q != 10'd0) begin state_d = ACTIVE; cnt_d = w_q; end
        else                   begin state_d = PAD_R;  cnt_d = r_q; end
      end
      PAD_L: if (cnt_q == 10'd1) begin
        if (w_q != 10'd0) begin state_d = ACTIVE; cnt_d = w_q; end
        else              begin state_d = PAD_R;  cnt_d = r_q; end
      end
      ACTIVE: if (cnt_q == 10'd1) begin
        if (r_q != 10'd0)                          begin state_d = PAD_R; cnt_d = r_q; end
        else if (x_q != 10'd0 && !bus.bank_empty)  begin state_d = DRAIN; cnt_d = x_q; end
        else                                       begin state_d = IDLE;  cnt_d = 10'd0; end
      end
      PAD_R: if (cnt_q == 10'd1) begin
        if (x_q != 10'd0 && !bus.bank_empty) begin state_d = DRAIN; cnt_d = x_q; end
        else                                 begin state_d = IDLE;  cnt_d = 10'd0; end
      end
      DRAIN: if (cnt_q == 10'd1 || bus.bank_empty) begin
        state_d = IDLE;
        cnt_d   = 10'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 10'd0;
      end
    endcase

    // A new hsync always wins, even over the final cycle of a line
    if (hs_edge) begin
      state_d = HS_WAIT;
      cnt_d   = LEAD;
      w_d     = w_new;
      x_d     = bus.line_width - w_new;
      l_d     = pad_new >> 1;
      r_d     = pad_new - (pad_new >> 1);
    end

    // Outputs are registered, so they are decoded from the state of the next cycle
    swap_bank_d = hs_edge;
    hsync_out_d = (state_d == HS_WAIT) && (cnt_d == HS_MARK);
    de_d        = (state_d == PAD_L) || (state_d == ACTIVE) || (state_d == PAD_R);
    read_ack_d  = ((state_d == ACTIVE) || (state_d == DRAIN)) && !bus.bank_empty;
    rgb_out_d   = ((state_d == ACTIVE) && !bus.bank_empty) ? bus.bank_q : 24'h0;
    vsync_out_d = vs_edge;
`ifdef LINE_SCHED_UNDERRUN_EN
    if ((state_d == ACTIVE) && bus.bank_empty) underrun_d = 1'b1;
    else if (vs_edge)                          underrun_d = 1'b0;
    else                                       underrun_d = underrun_q;
`else
    underrun_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 10'd0;
      l_q          <= 10'd0;
      w_q          <= 10'd0;
      r_q          <= 10'd0;
      x_q          <= 10'd0;
      prev_hsync_q <= 1'b0;
      prev_vsync_q <= 1'b0;
      swap_bank_q  <= 1'b0;
      read_ack_q   <= 1'b0;
      de_q         <= 1'b0;
      rgb_out_q    <= 24'h0;
      hsync_out_q  <= 1'b0;
      vsync_out_q  <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      l_q          <= l_d;
      w_q          <= w_d;
      r_q          <= r_d;
      x_q          <= x_d;
      prev_hsync_q <= prev_hsync_d;
      prev_vsync_q <= prev_vsync_d;
      swap_bank_q  <= swap_bank_d;
      read_ack_q   <= read_ack_d;
      de_q         <= de_d;
      rgb_out_q    <= rgb_out_d;
      hsync_out_q  <= hsync_out_d;
      vsync_out_q  <= vsync_out_d;
      underrun_q   <= underrun_d;
    end
  end

  assign bus.swap_bank = swap_bank_q;
  assign bus.read_ack  = read_ack_q;
  assign bus.de        = de_q;
  assign bus.rgb_out   = rgb_out_q;
  assign bus.hsync_out = hsync_out_q;
  assign bus.vsync_out = vsync_out_q;
  assign bus.underrun  = underrun_q;
endmodule

// File: tb/tb_line_output_scheduler.sv
// tb/tb_line_output_scheduler.sv - directed self-checking bench for line_output_scheduler
module tb_line_output_scheduler;
  localparam int HS_OFFSET = 6;
`ifdef LINE_SCHED_UNDERRUN_EN
  localparam logic EXP_UR = 1'b1;
`else
  localparam logic EXP_UR = 1'b0;
`endif

  logic clk_vid = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_vid = ~clk_vid;

  line_output_scheduler_if bus();

  line_output_scheduler #(.OUT_WIDTH(512), .HS_LEAD(15), .HS_OFFSET(HS_OFFSET)) dut (
    .clk_vid (clk_vid),
    .reset   (reset),
    .bus     (bus)
  );

  // Show-ahead bank model: a word being acknowledged is already gone from the head
  int rd_cnt = 0;
  int base   = 0;
  int avail  = 0;
  int head;
  always @(posedge clk_vid) if (bus.read_ack) rd_cnt <= rd_cnt + 1;
  assign head           = rd_cnt + int'(bus.read_ack);
  assign bus.bank_empty = (head >= base + avail);
  assign bus.bank_q     = {8'hA5, 16'(head - base)};

  int vectors = 0;
  int errors  = 0;

  int swap_n, swap_c, hs_n, hs_c, de_n, first_de, last_de;
  int rd_de, rd_nde, first_rd, last_rd, pix_err, k;
  logic ur_seen;

  task automatic step();
    @(posedge clk_vid);
    #1;
  endtask

  task automatic start_line(input int lw, input int n_avail);
    bus.line_width = 10'(lw);
    base  = head;
    avail = n_avail;
    bus.hsync_in = 1'b1;
  endtask

  task automatic collect(input int ncyc);
    swap_n = 0; swap_c = -1; hs_n = 0; hs_c = -1; de_n = 0; first_de = -1; last_de = -1;
    rd_de = 0; rd_nde = 0; first_rd = -1; last_rd = -1; pix_err = 0; k = 0; ur_seen = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      if (c == 1) bus.hsync_in = 1'b0;
      if (bus.swap_bank) begin swap_n++; if (swap_c < 0) swap_c = c; end
      if (bus.hsync_out) begin hs_n++; if (hs_c < 0) hs_c = c; end
      if (bus.de) begin de_n++; if (first_de < 0) first_de = c; last_de = c; end
      if (bus.read_ack) begin
        if (bus.de) rd_de++; else rd_nde++;
        if (first_rd < 0) first_rd = c;
        last_rd = c;
        if (bus.de && bus.rgb_out !== {8'hA5, 16'(k)}) pix_err++;
        k++;
      end else if (bus.de && bus.rgb_out !== 24'h0) pix_err++;
      if (bus.underrun) ur_seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus.hsync_in = 1'b0; bus.vsync_in = 1'b0; bus.line_width = 10'd0;
    reset = 1'b1;
    step(); step();
    vectors++; if (bus.de !== 1'b0) begin errors++; $display("FAIL reset_de got %b exp 0", bus.de); end
    vectors++; if (bus.read_ack !== 1'b0) begin errors++; $display("FAIL reset_read_ack got %b exp 0", bus.read_ack); end
    vectors++; if (bus.swap_bank !== 1'b0) begin errors++; $display("FAIL reset_swap got %b exp 0", bus.swap_bank); end
    vectors++; if (bus.hsync_out !== 1'b0 || bus.vsync_out !== 1'b0) begin errors++; $display("FAIL reset_syncs got %b%b exp 00", bus.hsync_out, bus.vsync_out); end
    vectors++; if (bus.rgb_out !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h exp 0", bus.rgb_out); end
    vectors++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b exp 0", bus.underrun); end
    reset = 1'b0;
    step(); step();
  endtask

  task automatic test_short_centered();
    start_line(256, 256);
    collect(540);
    vectors++; if (swap_c !== 1 || swap_n !== 1) begin errors++; $display("FAIL short_swap got cyc %0d n %0d exp cyc 1 n 1", swap_c, swap_n); end
    vectors++; if (hs_c !== HS_OFFSET + 1 || hs_n !== 1) begin errors++; $display("FAIL short_hsync got cyc %0d n %0d exp cyc %0d n 1", hs_c, hs_n, HS_OFFSET + 1); end
    vectors++; if (first_de !== 16) begin errors++; $display("FAIL short_first_de got %0d exp 16", first_de); end
    vectors++; if (de_n !== 512) begin errors++; $display("FAIL short_de_count got %0d exp 512", de_n); end
    vectors++; if (rd_de !== 256 || rd_nde !== 0) begin errors++; $display("FAIL short_reads got %0d/%0d exp 256/0", rd_de, rd_nde); end
    vectors++; if (first_rd !== 144 || last_rd !== 399) begin errors++; $display("FAIL short_read_window got %0d..%0d exp 144..399", first_rd, last_rd); end
    vectors++; if (last_de !== 527) begin errors++; $display("FAIL short_last_de got %0d exp 527", last_de); end
    vectors++; if (pix_err !== 0) begin errors++; $display("FAIL short_pixels got %0d bad exp 0", pix_err); end
  endtask

  task automatic test_odd_remainder();
    start_line(511, 511);
    collect(540);
    vectors++; if (first_de !== 16 || first_rd !== 16) begin errors++; $display("FAIL odd_first got de %0d rd %0d exp 16 16", first_de, first_rd); end
    vectors++; if (de_n !== 512 || rd_de !== 511) begin errors++; $display("FAIL odd_counts got de %0d rd %0d exp 512 511", de_n, rd_de); end
    vectors++; if (last_rd !== 526 || last_de !== 527) begin errors++; $display("FAIL odd_tail got rd %0d de %0d exp 526 527", last_rd, last_de); end
    vectors++; if (pix_err !== 0) begin errors++; $display("FAIL odd_pixels got %0d bad exp 0", pix_err); end
  endtask

  task automatic test_wide_drain();
    start_line(600, 600);
    collect(640);
    vectors++; if (de_n !== 512 || rd_de !== 512) begin errors++; $display("FAIL wide_display got de %0d rd %0d exp 512 512", de_n, rd_de); end
    vectors++; if (rd_nde !== 88) begin errors++; $display("FAIL wide_drain got %0d exp 88", rd_nde); end
    vectors++; if (last_rd !== 615) begin errors++; $display("FAIL wide_last_read got %0d exp 615", last_rd); end
    vectors++; if (rd_cnt - base !== 600) begin errors++; $display("FAIL wide_total_pops got %0d exp 600", rd_cnt - base); end
    vectors++; if (pix_err !== 0) begin errors++; $display("FAIL wide_pixels got %0d bad exp 0", pix_err); end
  endtask

  task automatic test_underrun();
    start_line(256, 100);
    collect(540);
    vectors++; if (de_n !== 512) begin errors++; $display("FAIL ur_de_count got %0d exp 512", de_n); end
    vectors++; if (rd_de !== 100) begin errors++; $display("FAIL ur_reads got %0d exp 100", rd_de); end
    vectors++; if (pix_err !== 0) begin errors++; $display("FAIL ur_pixels got %0d bad exp 0", pix_err); end
    vectors++; if (bus.underrun !== EXP_UR || ur_seen !== EXP_UR) begin errors++; $display("FAIL ur_flag got %b exp %b", bus.underrun, EXP_UR); end
    bus.vsync_in = 1'b1;
    step();
    vectors++; if (bus.vsync_out !== 1'b1) begin errors++; $display("FAIL vsync_pulse got %b exp 1", bus.vsync_out); end
    vectors++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL ur_clear got %b exp 0", bus.underrun); end
    step();
    vectors++; if (bus.vsync_out !== 1'b0) begin errors++; $display("FAIL vsync_one_cycle got %b exp 0", bus.vsync_out); end
    bus.vsync_in = 1'b0;
    step();
  endtask

  task automatic test_abort();
    start_line(512, 1000);
    collect(66);
    vectors++; if (rd_de !== 51 || pix_err !== 0) begin errors++; $display("FAIL abort_pre got %0d reads %0d bad exp 51 0", rd_de, pix_err); end
    start_line(256, 256);
    collect(540);
    vectors++; if (swap_c !== 1) begin errors++; $display("FAIL abort_swap got %0d exp 1", swap_c); end
    vectors++; if (first_de !== 16) begin errors++; $display("FAIL abort_first_de got %0d exp 16", first_de); end
    vectors++; if (de_n !== 512 || rd_de !== 256) begin errors++; $display("FAIL abort_counts got de %0d rd %0d exp 512 256", de_n, rd_de); end
    vectors++; if (first_rd !== 144 || pix_err !== 0) begin errors++; $display("FAIL abort_pixels got first %0d bad %0d exp 144 0", first_rd, pix_err); end
  endtask

  task automatic test_reset_mid_line();
    int stray;
    start_line(256, 256);
    collect(200);
    vectors++; if (bus.read_ack !== 1'b1) begin errors++; $display("FAIL rst_mid_active got %b exp 1", bus.read_ack); end
    reset = 1'b1;
    step();
    vectors++; if (bus.de !== 1'b0 || bus.read_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs got de %b ra %b exp 0 0", bus.de, bus.read_ack); end
    vectors++; if (bus.rgb_out !== 24'h0) begin errors++; $display("FAIL rst_mid_rgb got %h exp 0", bus.rgb_out); end
    step();
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.de || bus.read_ack) stray++;
    end
    vectors++; if (stray !== 0) begin errors++; $display("FAIL rst_mid_quiet got %0d active cycles exp 0", stray); end
    start_line(256, 256);
    collect(540);
    vectors++; if (de_n !== 512 || rd_de !== 256 || pix_err !== 0) begin errors++; $display("FAIL rst_mid_resume got de %0d rd %0d bad %0d exp 512 256 0", de_n, rd_de, pix_err); end
  endtask

  initial begin
    test_reset();
    test_short_centered();
    test_odd_remainder();
    test_wide_drain();
    test_underrun();
    test_abort();
    test_reset_mid_line();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
